// File: rtl/conv_channel_scheduler.sv
// Multi-channel sequencer for one convolution layer: per channel it resets/starts the layer,
// streams size*size activation words from memory and waits for the layer's done flag.
module conv_channel_scheduler #(
  parameter int N             = 8,
  parameter int MaxMatrixSize = 16383,
  parameter int MaxChannels   = 256,
  parameter int AddrWidth     = 24,
  localparam int ChW          = $clog2(MaxChannels + 1),
  localparam int SizeW        = $clog2(MaxMatrixSize + 1),
  localparam int CntW         = 2 * SizeW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ChW-1:0]       channel_count_i,
  input  logic [SizeW-1:0]     matrix_size_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  output logic                 act_rd_o,
  output logic [AddrWidth-1:0] act_addr_o,
  input  logic                 act_valid_i,
  input  logic [N-1:0]         act_data_i,
  output logic                 conv_rst_o,
  output logic                 conv_start_o,
  output logic                 conv_req_next_o,
  output logic [N-1:0]         conv_data_o,
  input  logic                 conv_done_i,
  output logic                 accumulate_o,
  output logic                 save_to_ram_o,
  output logic                 save_to_buffer_o,
  output logic [ChW-1:0]       channel_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_CSTART, S_STREAM, S_WAIT, S_DONE
  } state_t;

  state_t               state;
  logic [ChW-1:0]       count_q;
  logic [CntW-1:0]      total_q;
  logic [CntW-1:0]      word_cnt;
  logic [AddrWidth-1:0] ptr;
  logic                 is_last;
  logic                 next_is_last;

  assign is_last      = (channel_o == count_q - ChW'(1));
  assign next_is_last = (channel_o + ChW'(1) == count_q - ChW'(1));

  // Pulse outputs default low every cycle; abort overrides all in-flight activity.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= S_IDLE;
      count_q          <= '0;
      total_q          <= '0;
      word_cnt         <= '0;
      ptr              <= '0;
      act_rd_o         <= 1'b0;
      act_addr_o       <= '0;
      conv_rst_o       <= 1'b0;
      conv_start_o     <= 1'b0;
      conv_req_next_o  <= 1'b0;
      conv_data_o      <= '0;
      accumulate_o     <= 1'b0;
      save_to_ram_o    <= 1'b0;
      save_to_buffer_o <= 1'b0;
      channel_o        <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      conv_rst_o      <= 1'b0;
      conv_start_o    <= 1'b0;
      conv_req_next_o <= 1'b0;
      done_o          <= 1'b0;
      if (abort_i && state != S_IDLE) begin
        state            <= S_IDLE;
        conv_rst_o       <= 1'b1;
        act_rd_o         <= 1'b0;
        act_addr_o       <= '0;
        conv_data_o      <= '0;
        accumulate_o     <= 1'b0;
        save_to_ram_o    <= 1'b0;
        save_to_buffer_o <= 1'b0;
        channel_o        <= '0;
        busy_o           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              count_q   <= channel_count_i;
              total_q   <= CntW'(matrix_size_i) * CntW'(matrix_size_i);
              ptr       <= base_addr_i;
              channel_o <= '0;
              busy_o    <= 1'b1;
              if (channel_count_i == '0 || matrix_size_i == '0) begin
                state <= S_DONE;
              end else begin
                state            <= S_CRST;
                conv_rst_o       <= 1'b1;
                accumulate_o     <= 1'b0;
                save_to_buffer_o <= (channel_count_i == ChW'(1));
                save_to_ram_o    <= (channel_count_i != ChW'(1));
              end
            end
          end
          S_CRST: begin
            conv_start_o <= 1'b1;
            state        <= S_CSTART;
          end
          S_CSTART: begin
            word_cnt   <= '0;
            act_rd_o   <= 1'b1;
            act_addr_o <= ptr;
            state      <= S_STREAM;
          end
          S_STREAM: begin
            if (act_valid_i) begin
              conv_data_o     <= act_data_i;
              conv_req_next_o <= 1'b1;
              ptr             <= ptr + AddrWidth'(1);
              act_addr_o      <= ptr + AddrWidth'(1);
              word_cnt        <= word_cnt + CntW'(1);
              if (word_cnt + CntW'(1) == total_q) begin
                act_rd_o <= 1'b0;
                state    <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (conv_done_i) begin
              if (is_last) begin
                done_o           <= 1'b1;
                accumulate_o     <= 1'b0;
                save_to_ram_o    <= 1'b0;
                save_to_buffer_o <= 1'b0;
                state            <= S_DONE;
              end else begin
                channel_o        <= channel_o + ChW'(1);
                conv_rst_o       <= 1'b1;
                accumulate_o     <= 1'b1;
                save_to_buffer_o <= next_is_last;
                save_to_ram_o    <= !next_is_last;
                state            <= S_CRST;
              end
            end
          end
          // A degenerate start arrives here with done_o still low and spends one extra cycle.
          S_DONE: begin
            if (done_o) begin
              busy_o    <= 1'b0;
              channel_o <= '0;
              state     <= S_IDLE;
            end else begin
              done_o <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Directed bench for conv_channel_scheduler: memory responder, conv-layer done model,
// output monitor and a sequence of hand-checked scenarios.
module tb_conv_channel_scheduler;

  localparam int N   = 8;
  localparam int AW  = 24;
  localparam int ChW = 9;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic           abort_i;
  logic [ChW-1:0] channel_count_i = '0;
  logic [13:0]    matrix_size_i = '0;
  logic [AW-1:0]  base_addr_i = '0;
  logic           act_rd_o;
  logic [AW-1:0]  act_addr_o;
  logic           act_valid_i;
  logic [N-1:0]   act_data_i;
  logic           conv_rst_o;
  logic           conv_start_o;
  logic           conv_req_next_o;
  logic [N-1:0]   conv_data_o;
  logic           conv_done_i;
  logic           accumulate_o;
  logic           save_to_ram_o;
  logic           save_to_buffer_o;
  logic [ChW-1:0] channel_o;
  logic           busy_o;
  logic           done_o;

  conv_channel_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .channel_count_i(channel_count_i), .matrix_size_i(matrix_size_i), .base_addr_i(base_addr_i),
    .act_rd_o(act_rd_o), .act_addr_o(act_addr_o), .act_valid_i(act_valid_i), .act_data_i(act_data_i),
    .conv_rst_o(conv_rst_o), .conv_start_o(conv_start_o), .conv_req_next_o(conv_req_next_o),
    .conv_data_o(conv_data_o), .conv_done_i(conv_done_i), .accumulate_o(accumulate_o),
    .save_to_ram_o(save_to_ram_o), .save_to_buffer_o(save_to_buffer_o), .channel_o(channel_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] memWord(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Memory responder: acknowledges requests after random gaps, optionally firing abort with an ack.
  int max_gap = 0;
  int gap_left = 0;
  int ack_total = 0;
  int abort_at = -1;
  bit abort_fired = 1'b0;
  initial begin
    act_valid_i = 1'b0;
    act_data_i  = '0;
    abort_i     = 1'b0;
    forever begin
      @(negedge clk_i);
      act_valid_i = 1'b0;
      abort_i     = 1'b0;
      if (act_rd_o) begin
        if (gap_left > 0) begin
          gap_left--;
        end else begin
          act_valid_i = 1'b1;
          act_data_i  = memWord(act_addr_o);
          if (ack_total == abort_at) begin
            abort_i     = 1'b1;
            abort_fired = 1'b1;
          end
          ack_total++;
          gap_left = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        end
      end
    end
  end

  // Convolution layer model: raises done a few cycles after each channel's stream ends.
  bit auto_done = 1'b1;
  bit streamed = 1'b0;
  int wait_ctr = 0;
  initial begin
    conv_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      conv_done_i = 1'b0;
      if (!busy_o) begin
        streamed = 1'b0;
        wait_ctr = 0;
      end else if (act_rd_o) begin
        streamed = 1'b1;
      end else if (streamed && auto_done) begin
        wait_ctr++;
        if (wait_ctr == 3) begin
          conv_done_i = 1'b1;
          streamed    = 1'b0;
          wait_ctr    = 0;
        end
      end
    end
  end

  // Output monitor: checks data and held addresses, tallies pulses and per-channel flags.
  int n_req, n_crst, n_cstart, n_done, n_rd;
  logic [AW-1:0] exp_addr = '0;
  int   rec_ch [4];
  logic rec_acc [4];
  logic rec_ram [4];
  logic rec_buf [4];
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (conv_req_next_o) begin
          checkOutput("conv_data", 32'(conv_data_o), 32'(memWord(exp_addr)));
          exp_addr = exp_addr + 1'b1;
          n_req++;
        end
        if (act_rd_o) begin
          n_rd++;
          checkOutput("act_addr", 32'(act_addr_o), 32'(exp_addr));
        end
        if (conv_rst_o) n_crst++;
        if (conv_start_o) begin
          if (n_cstart < 4) begin
            rec_ch[n_cstart]  = int'(channel_o);
            rec_acc[n_cstart] = accumulate_o;
            rec_ram[n_cstart] = save_to_ram_o;
            rec_buf[n_cstart] = save_to_buffer_o;
          end
          n_cstart++;
        end
        if (done_o) n_done++;
      end
    end
  end

  task automatic clearCounters();
    n_req = 0; n_crst = 0; n_cstart = 0; n_done = 0; n_rd = 0;
    ack_total = 0; abort_fired = 1'b0; gap_left = 0;
  endtask

  task automatic applyStimulus(input int ch, input int sz, input logic [AW-1:0] base);
    clearCounters();
    exp_addr        = base;
    channel_count_i = ChW'(ch);
    matrix_size_i   = 14'(sz);
    base_addr_i     = base;
    start_i         = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int c = 0;
    while (!done_o && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    checkOutput("done_seen", 32'(done_o), 1);
    checkOutput("busy_at_done", 32'(busy_o), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    #12;
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_act_rd", 32'(act_rd_o), 0);
    checkOutput("rst_conv_rst", 32'(conv_rst_o), 0);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_channel", 32'(channel_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("[TB] single channel 5x5");
    applyStimulus(1, 5, 24'h100);
    checkOutput("t1_busy", 32'(busy_o), 1);
    checkOutput("t1_conv_rst", 32'(conv_rst_o), 1);
    @(negedge clk_i);
    checkOutput("t1_conv_start", 32'(conv_start_o), 1);
    @(negedge clk_i);
    checkOutput("t1_act_rd", 32'(act_rd_o), 1);
    waitDone(200);
    @(negedge clk_i);
    checkOutput("t1_busy_after", 32'(busy_o), 0);
    checkOutput("t1_done_after", 32'(done_o), 0);
    checkOutput("t1_words", 32'(n_req), 25);
    checkOutput("t1_end_addr", 32'(exp_addr), 32'h119);
    checkOutput("t1_cstarts", 32'(n_cstart), 1);
    checkOutput("t1_acc", 32'(rec_acc[0]), 0);
    checkOutput("t1_buf", 32'(rec_buf[0]), 1);
    checkOutput("t1_ram", 32'(rec_ram[0]), 0);
    checkOutput("t1_dones", 32'(n_done), 1);

    $display("[TB] three channels 4x4");
    applyStimulus(3, 4, 24'h2000);
    waitDone(600);
    channel_count_i = 9'd1;
    matrix_size_i   = 14'd2;
    start_i         = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("t2_start_in_done_ignored", 32'(busy_o), 0);
    checkOutput("t2_words", 32'(n_req), 48);
    checkOutput("t2_end_addr", 32'(exp_addr), 32'h2030);
    checkOutput("t2_crsts", 32'(n_crst), 3);
    checkOutput("t2_cstarts", 32'(n_cstart), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_ch%0d", i), 32'(rec_ch[i]), 32'(i));
      checkOutput($sformatf("t2_acc%0d", i), 32'(rec_acc[i]), (i != 0) ? 1 : 0);
      checkOutput($sformatf("t2_ram%0d", i), 32'(rec_ram[i]), (i != 2) ? 1 : 0);
      checkOutput($sformatf("t2_buf%0d", i), 32'(rec_buf[i]), (i == 2) ? 1 : 0);
    end
    checkOutput("t2_dones", 32'(n_done), 1);

    $display("[TB] random stalls with address wrap");
    max_gap = 5;
    applyStimulus(2, 3, 24'hFFFFFC);
    waitDone(1000);
    @(negedge clk_i);
    max_gap = 0;
    checkOutput("t3_words", 32'(n_req), 18);
    checkOutput("t3_end_addr", 32'(exp_addr), 32'h00000E);
    checkOutput("t3_cstarts", 32'(n_cstart), 2);
    checkOutput("t3_dones", 32'(n_done), 1);

    $display("[TB] degenerate configurations");
    for (int k = 0; k < 2; k++) begin
      applyStimulus((k == 0) ? 0 : 2, (k == 0) ? 5 : 0, 24'h10);
      checkOutput("t4_done_e0", 32'(done_o), 0);
      checkOutput("t4_busy_e0", 32'(busy_o), 1);
      @(negedge clk_i);
      checkOutput("t4_done_e1", 32'(done_o), 1);
      @(negedge clk_i);
      checkOutput("t4_done_e2", 32'(done_o), 0);
      checkOutput("t4_busy_e2", 32'(busy_o), 0);
      checkOutput("t4_crsts", 32'(n_crst), 0);
      checkOutput("t4_cstarts", 32'(n_cstart), 0);
      checkOutput("t4_rd_cycles", 32'(n_rd), 0);
      checkOutput("t4_dones", 32'(n_done), 1);
    end

    $display("[TB] abort on word 7 of channel 1");
    abort_at = 23;
    applyStimulus(3, 4, 24'h40);
    c = 0;
    while (!abort_fired && c < 600) begin
      @(posedge clk_i);
      c++;
    end
    checkOutput("t5_abort_issued", 32'(abort_fired), 1);
    #1;
    abort_at = -1;
    checkOutput("t5_conv_rst", 32'(conv_rst_o), 1);
    checkOutput("t5_req_next", 32'(conv_req_next_o), 0);
    checkOutput("t5_busy", 32'(busy_o), 0);
    checkOutput("t5_act_rd", 32'(act_rd_o), 0);
    checkOutput("t5_acc", 32'(accumulate_o), 0);
    checkOutput("t5_ram", 32'(save_to_ram_o), 0);
    checkOutput("t5_buf", 32'(save_to_buffer_o), 0);
    checkOutput("t5_channel", 32'(channel_o), 0);
    @(posedge clk_i);
    #1;
    checkOutput("t5_conv_rst_drop", 32'(conv_rst_o), 0);
    repeat (10) @(negedge clk_i);
    checkOutput("t5_words", 32'(n_req), 23);
    checkOutput("t5_crsts", 32'(n_crst), 3);
    checkOutput("t5_cstarts", 32'(n_cstart), 2);
    checkOutput("t5_dones", 32'(n_done), 0);
    applyStimulus(1, 2, 24'h80);
    waitDone(200);
    @(negedge clk_i);
    checkOutput("t5_rerun_words", 32'(n_req), 4);
    checkOutput("t5_rerun_ch", 32'(rec_ch[0]), 0);
    checkOutput("t5_rerun_acc", 32'(rec_acc[0]), 0);
    checkOutput("t5_rerun_dones", 32'(n_done), 1);

    $display("[TB] async reset in WAIT");
    auto_done = 1'b0;
    applyStimulus(1, 2, 24'h300);
    c = 0;
    while (!(n_req == 4 && !act_rd_o) && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    checkOutput("t6_in_wait_busy", 32'(busy_o), 1);
    checkOutput("t6_in_wait_buf", 32'(save_to_buffer_o), 1);
    @(posedge clk_i);
    #3;
    rst_ni  = 1'b0;
    start_i = 1'b1;
    #1;
    checkOutput("t6_busy", 32'(busy_o), 0);
    checkOutput("t6_buf", 32'(save_to_buffer_o), 0);
    checkOutput("t6_ram", 32'(save_to_ram_o), 0);
    checkOutput("t6_act_rd", 32'(act_rd_o), 0);
    checkOutput("t6_done", 32'(done_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t6_start_ignored_busy", 32'(busy_o), 0);
    checkOutput("t6_start_ignored_rst", 32'(conv_rst_o), 0);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("t6_idle_after", 32'(busy_o), 0);
    auto_done = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
